// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester main-memory arbiter:
// FSM state encodings, requester IDs, default read latency and the
// return-pipeline entry layout.
package mem_arb_pkg;

  // Arbiter FSM states
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] OWN_I = 2'b01;
  localparam logic [1:0] OWN_D = 2'b10;

  // Requester IDs, also used as return-pipeline tags
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Cycles from an accepted read to valid memory read data
  localparam int MEM_LAT_DEF = 2;

  // One slot of the read-return pipeline
  typedef struct packed {
    logic valid;
    logic tag;
  } rtn_entry_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus between one cache controller and the arbiter.
// The cache controller uses the master modport, the arbiter the slave.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          rd;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          stall;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, rd, wr, addr, wdata,
    input  gnt, stall, rvalid, rdata
  );

  modport slave (
    input  req, rd, wr, addr, wdata,
    output gnt, stall, rvalid, rdata
  );
endinterface

// File: rtl/mem_arb_rtn_pipe.sv
// Tagged read-return shift register. Each accepted read enters as
// {valid, tag}; the tail entry lines up with the memory read data.
module mem_arb_rtn_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = MEM_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  rtn_entry_t push_i,
  output rtn_entry_t tail_o
);

  rtn_entry_t pipe_q [DEPTH];

  // Shift one slot per cycle; reset discards every in-flight read
  // NOTE: this storage is reset on purpose -- a stale valid bit would
  // raise rvalid for a read that no longer exists after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every slot read the
      // pre-edge value of its neighbour, giving a true shift.
      pipe_q[0] <= push_i;
      for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the four-bank main memory.
// Whole-transaction ownership with round-robin tie-break, owner mux to
// the memory port, stall forwarding and tagged read-data return.
// Optional build macro MEM_ARB_ERR_EN adds a sticky protocol-error
// output 'err'.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  i_bus,
  mem_arbiter_if.slave  d_bus,
  output logic [AW-1:0] Addr_mem,
  output logic [DW-1:0] DataIn_mem,
  output logic          rd_mem,
  output logic          wr_mem,
  input  logic [DW-1:0] DataOut_mem,
  input  logic          stall
`ifdef MEM_ARB_ERR_EN
  ,
  output logic          err
`endif
);

  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       own_i, own_d;
  rtn_entry_t rtn_push, rtn_tail;

  // Next-state and round-robin bookkeeping
  // NOTE: defaults first so every path assigns both outputs and no
  // latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (i_bus.req && d_bus.req)
          state_d = (last_owner_q == REQ_I) ? OWN_D : OWN_I;
        else if (i_bus.req)
          state_d = OWN_I;
        else if (d_bus.req)
          state_d = OWN_D;
      end
      OWN_I: begin
        if (!i_bus.req) begin
          last_owner_d = REQ_I;
          state_d      = d_bus.req ? OWN_D : IDLE;
        end
      end
      OWN_D: begin
        if (!d_bus.req) begin
          last_owner_d = REQ_D;
          state_d      = i_bus.req ? OWN_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and last-owner registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_owner_q <= REQ_I;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Grants are a pure decode of registered state: no req->gnt path
  assign own_i = (state_q == OWN_I);
  assign own_d = (state_q == OWN_D);
  assign i_bus.gnt = own_i;
  assign d_bus.gnt = own_d;

  // Memory-port mux by owner; a simultaneous rd & wr resolves to write
  always_comb begin
    Addr_mem   = '0;
    DataIn_mem = '0;
    rd_mem     = 1'b0;
    wr_mem     = 1'b0;
    if (own_i) begin
      Addr_mem   = i_bus.addr;
      DataIn_mem = i_bus.wdata;
      wr_mem     = i_bus.wr;
      rd_mem     = i_bus.rd & ~i_bus.wr;
    end else if (own_d) begin
      Addr_mem   = d_bus.addr;
      DataIn_mem = d_bus.wdata;
      wr_mem     = d_bus.wr;
      rd_mem     = d_bus.rd & ~d_bus.wr;
    end
  end

  // Owner sees the memory stall; a non-owner strobe is always stalled.
  // The non-owner term is masked during reset so every output is 0.
  assign i_bus.stall = own_i ? stall : (rst & (i_bus.rd | i_bus.wr));
  assign d_bus.stall = own_d ? stall : (rst & (d_bus.rd | d_bus.wr));

  // Tag each accepted read with its issuer; tail steers rvalid
  assign rtn_push.valid = rd_mem & ~stall;
  assign rtn_push.tag   = own_d ? REQ_D : REQ_I;

  mem_arb_rtn_pipe #(
    .DEPTH (MEM_LAT)
  ) u_rtn_pipe (
    .clk    (clk),
    .rst    (rst),
    .push_i (rtn_push),
    .tail_o (rtn_tail)
  );

  assign i_bus.rvalid = rtn_tail.valid & (rtn_tail.tag == REQ_I);
  assign d_bus.rvalid = rtn_tail.valid & (rtn_tail.tag == REQ_D);
  assign i_bus.rdata  = DataOut_mem;
  assign d_bus.rdata  = DataOut_mem;

`ifdef MEM_ARB_ERR_EN
  logic err_q;
  logic err_hit;

  // Protocol violations: ungranted strobe with req low, owner rd & wr
  // together, owner dropping req while its strobe is stalled
  always_comb begin
    err_hit = ((i_bus.rd | i_bus.wr) & ~own_i & ~i_bus.req)
            | ((d_bus.rd | d_bus.wr) & ~own_d & ~d_bus.req)
            | (own_i & i_bus.rd & i_bus.wr)
            | (own_d & d_bus.rd & d_bus.wr)
            | (own_i & ~i_bus.req & (i_bus.rd | i_bus.wr) & stall)
            | (own_d & ~d_bus.req & (d_bus.rd | d_bus.wr) & stall);
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | err_hit;
  end

  assign err = err_q;
`endif

endmodule
